// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: type codes, FSM states,
// bus command payload and the default bus timeout.
package mem_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned BE_W            = 4;
  localparam int unsigned DT_W            = 3;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  typedef enum logic [DT_W-1:0] {
    DT_WORD  = 3'b000,
    DT_HALF  = 3'b001,
    DT_HALFU = 3'b010,
    DT_BYTE  = 3'b011,
    DT_BYTEU = 3'b100
  } data_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Registered bus command, launched on IDLE->REQ and held until ack.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } bus_cmd_t;

  // Word needs 4-byte alignment, halfword 2-byte; bytes are always aligned.
  function automatic logic is_misaligned(input logic [DT_W-1:0] dt,
                                         input logic [1:0]      lo);
    logic mis;
    mis = 1'b0;
    if (dt == DT_WORD) begin
      mis = (lo != 2'b00);
    end else if ((dt == DT_HALF) || (dt == DT_HALFU)) begin
      mis = lo[0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory bus between the access unit (master) and the memory side (slave).
interface mem_access_unit_if;

  logic                         bus_req;
  logic                         bus_we;
  logic [mem_pkg::XLEN-1:0]     bus_addr;
  logic [mem_pkg::XLEN-1:0]     bus_wdata;
  logic [mem_pkg::BE_W-1:0]     bus_be;
  logic                         bus_ack;
  logic [mem_pkg::XLEN-1:0]     bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables, store replication and load extraction.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [DT_W-1:0] dtype_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [BE_W-1:0] be_c_o,
  output logic [XLEN-1:0] wdata_c_o,
  output logic [XLEN-1:0] rdata_c_o
);

  logic [15:0] lane16;
  logic [7:0]  lane8;

  // Select the halfword / byte lane addressed by the low address bits.
  always_comb begin
    lane16 = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    lane8  = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    lane8 = rdata_i[15:8];
      2'd2:    lane8 = rdata_i[23:16];
      2'd3:    lane8 = rdata_i[31:24];
      default: lane8 = rdata_i[7:0];
    endcase
  end

  // Per-type enables, replicated store data and extended load data.
  always_comb begin
    be_c_o    = 4'b1111;
    wdata_c_o = wdata_i;
    rdata_c_o = rdata_i;
    case (dtype_i)
      DT_HALF, DT_HALFU: begin
        be_c_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_c_o = {2{wdata_i[15:0]}};
        rdata_c_o = (dtype_i == DT_HALF) ? {{16{lane16[15]}}, lane16}
                                          : {16'h0000, lane16};
      end
      DT_BYTE, DT_BYTEU: begin
        be_c_o    = 4'b0001 << addr_lo_i;
        wdata_c_o = {4{wdata_i[7:0]}};
        rdata_c_o = (dtype_i == DT_BYTE) ? {{24{lane8[7]}}, lane8}
                                          : {24'h000000, lane8};
      end
      default: begin
        be_c_o    = 4'b1111;
        wdata_c_o = wdata_i;
        rdata_c_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one bus transaction per request, stalls
// the pipeline until ack or timeout, returns extended load data.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned word/half accesses are
// rejected without a bus request and reported on err_o.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [DT_W-1:0]   data_type_m,
  input  logic [XLEN-1:0]   addr_m,
  input  logic [XLEN-1:0]   wdata_m,
  output logic              stall_o,
  output logic              done_o,
  output logic              err_o,
  output logic [XLEN-1:0]   rdata_o,
  mem_access_unit_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  bus_cmd_t          cmd_q, cmd_d;
  logic              bus_req_q, bus_req_d;
  logic              load_q, load_d;
  logic [DT_W-1:0]   dtype_q, dtype_d;
  logic [1:0]        lo_q, lo_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic              req_c;
  logic              misalign_c;
  logic              timeout_c;
  logic [DT_W-1:0]   align_dt_c;
  logic [1:0]        align_lo_c;
  logic [BE_W-1:0]   align_be_c;
  logic [XLEN-1:0]   align_wdata_c;
  logic [XLEN-1:0]   align_rdata_c;

  assign req_c     = mem_read_m | mem_write_m;
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_c = is_misaligned(data_type_m, addr_m[1:0]);
`else
  assign misalign_c = 1'b0;
`endif

  // Lane logic sees the live request in IDLE and the captured one afterwards.
  assign align_dt_c = (state_q == ST_IDLE) ? data_type_m : dtype_q;
  assign align_lo_c = (state_q == ST_IDLE) ? addr_m[1:0] : lo_q;

  mem_lane_align u_lane_align (
    .dtype_i   (align_dt_c),
    .addr_lo_i (align_lo_c),
    .wdata_i   (wdata_m),
    .rdata_i   (bus.bus_rdata),
    .be_c_o    (align_be_c),
    .wdata_c_o (align_wdata_c),
    .rdata_c_o (align_rdata_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests seen in DONE belong to the held instruction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          state_d = misalign_c ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.bus_ack || timeout_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: combinational stall plus next values of registered outputs.
  always_comb begin
    stall_o   = 1'b0;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    bus_req_d = bus_req_q;
    load_d    = load_q;
    dtype_d   = dtype_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    case (state_q)
      ST_IDLE: begin
        stall_o = req_c;
        cnt_d   = '0;
        if (req_c) begin
          if (misalign_c) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            bus_req_d   = 1'b1;
            cmd_d.we    = mem_write_m;
            cmd_d.addr  = {addr_m[XLEN-1:2], 2'b00};
            cmd_d.wdata = align_wdata_c;
            cmd_d.be    = align_be_c;
            load_d      = mem_read_m & ~mem_write_m;
            dtype_d     = data_type_m;
            lo_d        = addr_m[1:0];
          end
        end
      end
      ST_REQ: begin
        stall_o = 1'b1;
        if (bus.bus_ack) begin
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          rdata_d   = load_q ? align_rdata_c : '0;
        end else if (timeout_c) begin
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        stall_o = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      cmd_q     <= '0;
      bus_req_q <= 1'b0;
      load_q    <= 1'b0;
      dtype_q   <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      bus_req_q <= bus_req_d;
      load_q    <= load_d;
      dtype_q   <= dtype_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign done_o        = done_q;
  assign err_o         = err_q;
  assign rdata_o       = rdata_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = cmd_q.we;
  assign bus.bus_addr  = cmd_q.addr;
  assign bus.bus_wdata = cmd_q.wdata;
  assign bus.bus_be    = cmd_q.be;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized transactions
// checked against an arithmetic reference model.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_m, mem_write_m;
  logic [2:0]  data_type_m;
  logic [31:0] addr_m, wdata_m;
  logic        stall_o, done_o, err_o;
  logic [31:0] rdata_o;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT_CYC(TO)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read_m  (mem_read_m),
    .mem_write_m (mem_write_m),
    .data_type_m (data_type_m),
    .addr_m      (addr_m),
    .wdata_m     (wdata_m),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Observations of the last transaction.
  int          o_stall, o_done, o_err, o_reqcyc, o_post_req, o_leak;
  bit          o_stable, o_hung, o_req_at_done;
  logic        o_we;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_be;

  // Reference model.
  function automatic logic [3:0] model_be(input int dt, input logic [31:0] a);
    int lo = int'(a[1:0]);
    if (dt == 1 || dt == 2) return (lo >= 2) ? 4'hC : 4'h3;
    if (dt == 3 || dt == 4) return 4'((1 << lo));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input int dt, input logic [31:0] w);
    if (dt == 1 || dt == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    if (dt == 3 || dt == 4) return (w & 32'hFF) * 32'h0101_0101;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input int dt, input logic [31:0] a,
                                             input logic [31:0] word);
    longint v;
    int lo = int'(a[1:0]);
    if (dt == 1 || dt == 2) begin
      v = (longint'(word) >> ((lo / 2) * 16)) % 65536;
      if (dt == 1 && v >= 32768) v = v - 65536;
      return v[31:0];
    end
    if (dt == 3 || dt == 4) begin
      v = (longint'(word) >> (lo * 8)) % 256;
      if (dt == 3 && v >= 128) v = v - 256;
      return v[31:0];
    end
    return word;
  endfunction

  function automatic bit model_mis(input int dt, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    if (dt == 0) return (a % 4) != 0;
    if (dt == 1 || dt == 2) return (a % 2) != 0;
`endif
    return 1'b0;
  endfunction

  // Drives one request, acks after ack_after bus_req cycles (0: never),
  // records what it saw. Starts and ends 1ns after a rising edge.
  task automatic run_txn(input bit rd, input bit wr, input logic [2:0] dt,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int ack_after, input logic [31:0] ack_data);
    bit got_done = 1'b0;
    o_stall = 0; o_done = 0; o_err = 0; o_reqcyc = 0; o_post_req = 0; o_leak = 0;
    o_stable = 1'b1; o_hung = 1'b0; o_req_at_done = 1'b0;
    o_we = 1'b0; o_addr = '0; o_wdata = '0; o_be = '0; o_rdata = '0;
    mem_read_m = rd; mem_write_m = wr; data_type_m = dt; addr_m = a; wdata_m = wd;
    for (int cyc = 0; cyc < int'(TO) + 10 && !got_done; cyc++) begin
      @(negedge clk);
      if (stall_o) o_stall++;
      if (!done_o && rdata_o !== 32'h0) o_leak++;
      if (bus_if.bus_req) begin
        o_reqcyc++;
        if (o_reqcyc == 1) begin
          o_we = bus_if.bus_we; o_addr = bus_if.bus_addr;
          o_wdata = bus_if.bus_wdata; o_be = bus_if.bus_be;
        end else if (o_we !== bus_if.bus_we || o_addr !== bus_if.bus_addr ||
                     o_wdata !== bus_if.bus_wdata || o_be !== bus_if.bus_be) begin
          o_stable = 1'b0;
        end
        if (o_reqcyc == ack_after) begin
          bus_if.bus_ack = 1'b1;
          bus_if.bus_rdata = ack_data;
        end
      end
      if (done_o) begin
        got_done = 1'b1;
        o_done++;
        o_rdata = rdata_o;
        o_req_at_done = bus_if.bus_req;
      end
      if (err_o) o_err++;
      @(posedge clk); #1;
      bus_if.bus_ack = 1'b0;
      bus_if.bus_rdata = $urandom;
    end
    o_hung = !got_done;
    mem_read_m = 1'b0; mem_write_m = 1'b0;
    data_type_m = 3'($urandom_range(0, 4)); addr_m = $urandom; wdata_m = $urandom;
    if (o_hung) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end
    repeat (2) begin
      @(negedge clk);
      if (bus_if.bus_req) o_post_req++;
      if (done_o) o_done++;
      if (err_o) o_err++;
      if (stall_o) o_stall++;
      if (rdata_o !== 32'h0) o_leak++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_read_m = 1'b0; mem_write_m = 1'b0; data_type_m = '0; addr_m = '0; wdata_m = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if ({stall_o, done_o, err_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got %b exp 000", {stall_o, done_o, err_o}); end
    n_vec++; if (rdata_o !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata got %h exp 0", rdata_o); end
    n_vec++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_be} !== 6'b0) begin
      n_err++; $display("FAIL reset_bus_ctl got %b exp 0", {bus_if.bus_req, bus_if.bus_we, bus_if.bus_be}); end
    n_vec++; if (bus_if.bus_addr !== 32'h0 || bus_if.bus_wdata !== 32'h0) begin
      n_err++; $display("FAIL reset_bus_data got %h/%h exp 0", bus_if.bus_addr, bus_if.bus_wdata); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_word_load();
    run_txn(1'b1, 1'b0, DT_WORD, 32'h100, 32'h1234_5678, 3, 32'hDEAD_BEEF);
    n_vec++; if (o_stall !== 4) begin n_err++; $display("FAIL wl_stall got %0d exp 4", o_stall); end
    n_vec++; if (o_done !== 1) begin n_err++; $display("FAIL wl_done got %0d exp 1", o_done); end
    n_vec++; if (o_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wl_rdata got %h exp deadbeef", o_rdata); end
    n_vec++; if ({o_we, o_be, o_addr} !== {1'b0, 4'hF, 32'h100}) begin
      n_err++; $display("FAIL wl_bus got we%b be%b addr%h exp we0 be1111 addr100", o_we, o_be, o_addr); end
    n_vec++; if (o_err !== 0 || o_reqcyc !== 3 || o_post_req !== 0) begin
      n_err++; $display("FAIL wl_misc got err%0d req%0d post%0d exp 0 3 0", o_err, o_reqcyc, o_post_req); end
  endtask

  task automatic test_byte_load_signed();
    run_txn(1'b1, 1'b0, DT_BYTE, 32'h103, 32'h0, 1, 32'h8011_2233);
    n_vec++; if (o_be !== 4'b1000) begin n_err++; $display("FAIL bls_be got %b exp 1000", o_be); end
    n_vec++; if (o_rdata !== 32'hFFFF_FF80) begin n_err++; $display("FAIL bls_rdata got %h exp ffffff80", o_rdata); end
    n_vec++; if (o_addr !== 32'h100) begin n_err++; $display("FAIL bls_addr got %h exp 100", o_addr); end
  endtask

  task automatic test_half_store();
    run_txn(1'b0, 1'b1, DT_HALFU, 32'h202, 32'h0000_ABCD, 2, 32'h5555_5555);
    n_vec++; if (o_we !== 1'b1) begin n_err++; $display("FAIL hs_we got %b exp 1", o_we); end
    n_vec++; if (o_be !== 4'b1100) begin n_err++; $display("FAIL hs_be got %b exp 1100", o_be); end
    n_vec++; if (o_wdata !== 32'hABCD_ABCD) begin n_err++; $display("FAIL hs_wdata got %h exp abcdabcd", o_wdata); end
    n_vec++; if (o_rdata !== 32'h0 || o_done !== 1) begin
      n_err++; $display("FAIL hs_done got rdata%h done%0d exp 0 1", o_rdata, o_done); end
  endtask

  task automatic test_both_high();
    run_txn(1'b1, 1'b1, DT_WORD, 32'h40, 32'hCAFE_F00D, 1, 32'h7777_7777);
    n_vec++; if (o_we !== 1'b1 || o_wdata !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL both_store got we%b wdata%h exp 1 cafef00d", o_we, o_wdata); end
    n_vec++; if (o_rdata !== 32'h0) begin n_err++; $display("FAIL both_rdata got %h exp 0", o_rdata); end
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 1'b0, DT_WORD, 32'h80, 32'h0, 0, 32'h0);
    n_vec++; if (o_err !== 1 || o_done !== 1) begin
      n_err++; $display("FAIL to_pulse got err%0d done%0d exp 1 1", o_err, o_done); end
    n_vec++; if (o_reqcyc !== int'(TO) || o_req_at_done !== 1'b0) begin
      n_err++; $display("FAIL to_req got cyc%0d reqdone%b exp %0d 0", o_reqcyc, o_req_at_done, TO); end
    n_vec++; if (o_stall !== int'(TO) + 1 || o_hung !== 1'b0) begin
      n_err++; $display("FAIL to_stall got %0d hung%b exp %0d 0", o_stall, o_hung, TO + 1); end
    n_vec++; if (o_rdata !== 32'h0) begin n_err++; $display("FAIL to_rdata got %h exp 0", o_rdata); end
  endtask

  task automatic test_reset_mid_req();
    int rc = 0;
    mem_read_m = 1'b1; mem_write_m = 1'b0; data_type_m = DT_WORD;
    addr_m = 32'h300; wdata_m = 32'h3;
    for (int c = 0; c < 10 && rc < 2; c++) begin
      @(negedge clk);
      if (bus_if.bus_req) rc++;
      if (rc < 2) begin @(posedge clk); #1; end
    end
    n_vec++; if (rc !== 2) begin n_err++; $display("FAIL rst_mid_reach got %0d exp 2", rc); end
    reset = 1'b1;
    mem_read_m = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (bus_if.bus_req !== 1'b0 || stall_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_req got req%b stall%b exp 0 0", bus_if.bus_req, stall_o); end
    n_vec++; if ({done_o, err_o, rdata_o, bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr} !== '0) begin
      n_err++; $display("FAIL rst_mid_outs got done%b err%b rdata%h addr%h exp 0", done_o, err_o, rdata_o, bus_if.bus_addr); end
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, DT_BYTEU, 32'h301, 32'h0, 1, 32'h1122_3344);
    n_vec++; if (o_stall !== 2 || o_done !== 1 || o_rdata !== 32'h33) begin
      n_err++; $display("FAIL rst_mid_after got stall%0d done%0d rdata%h exp 2 1 33", o_stall, o_done, o_rdata); end
  endtask

  task automatic test_misalign();
    run_txn(1'b1, 1'b0, DT_WORD, 32'h101, 32'h0, 1, 32'hA1B2_C3D4);
`ifdef MEM_ALIGN_CHECK_EN
    n_vec++; if (o_reqcyc !== 0 || o_stall !== 1) begin
      n_err++; $display("FAIL mis_nobus got req%0d stall%0d exp 0 1", o_reqcyc, o_stall); end
    n_vec++; if (o_err !== 1 || o_done !== 1 || o_rdata !== 32'h0) begin
      n_err++; $display("FAIL mis_err got err%0d done%0d rdata%h exp 1 1 0", o_err, o_done, o_rdata); end
`else
    n_vec++; if (o_reqcyc !== 1 || o_be !== 4'hF || o_addr !== 32'h100) begin
      n_err++; $display("FAIL mis_ign got req%0d be%b addr%h exp 1 1111 100", o_reqcyc, o_be, o_addr); end
    n_vec++; if (o_err !== 0 || o_rdata !== 32'hA1B2_C3D4) begin
      n_err++; $display("FAIL mis_rdata got err%0d rdata%h exp 0 a1b2c3d4", o_err, o_rdata); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int kind = int'($urandom_range(0, 2));
      bit rd = (kind != 1);
      bit wr = (kind != 0);
      int dt = int'($urandom_range(0, 4));
      logic [31:0] a = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] ad = $urandom;
      int ack_after = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
      bit mis = model_mis(dt, a);
      int e_req, e_stall, e_err;
      logic [31:0] e_rdata;
      run_txn(rd, wr, 3'(dt), a, wd, ack_after, ad);
      if (mis) begin
        e_req = 0; e_stall = 1; e_err = 1; e_rdata = '0;
      end else if (ack_after == 0) begin
        e_req = int'(TO); e_stall = int'(TO) + 1; e_err = 1; e_rdata = '0;
      end else begin
        e_req = ack_after; e_stall = ack_after + 1; e_err = 0;
        e_rdata = wr ? 32'h0 : model_load(dt, a, ad);
      end
      n_vec++; if (o_reqcyc !== e_req) begin n_err++; $display("FAIL rnd%0d reqcyc got %0d exp %0d", i, o_reqcyc, e_req); end
      n_vec++; if (o_stall !== e_stall) begin n_err++; $display("FAIL rnd%0d stall got %0d exp %0d", i, o_stall, e_stall); end
      n_vec++; if (o_done !== 1) begin n_err++; $display("FAIL rnd%0d done got %0d exp 1", i, o_done); end
      n_vec++; if (o_err !== e_err) begin n_err++; $display("FAIL rnd%0d err got %0d exp %0d", i, o_err, e_err); end
      n_vec++; if (o_rdata !== e_rdata) begin n_err++; $display("FAIL rnd%0d rdata got %h exp %h", i, o_rdata, e_rdata); end
      n_vec++; if (o_leak !== 0 || o_post_req !== 0 || o_req_at_done !== 1'b0) begin
        n_err++; $display("FAIL rnd%0d idle got leak%0d post%0d reqdone%b exp 0", i, o_leak, o_post_req, o_req_at_done); end
      if (!mis) begin
        n_vec++; if (o_we !== wr || o_addr !== (a & 32'hFFFF_FFFC)) begin
          n_err++; $display("FAIL rnd%0d we_addr got %b %h exp %b %h", i, o_we, o_addr, wr, a & 32'hFFFF_FFFC); end
        n_vec++; if (o_be !== model_be(dt, a)) begin
          n_err++; $display("FAIL rnd%0d be got %b exp %b", i, o_be, model_be(dt, a)); end
        n_vec++; if (o_stable !== 1'b1) begin n_err++; $display("FAIL rnd%0d bus_hold got %b exp 1", i, o_stable); end
        if (wr) begin
          n_vec++; if (o_wdata !== model_wdata(dt, wd)) begin
            n_err++; $display("FAIL rnd%0d wdata got %h exp %h", i, o_wdata, model_wdata(dt, wd)); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load_signed();
    test_half_store();
    test_both_high();
    test_timeout();
    test_reset_mid_req();
    test_misalign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, meaning bus wait cycles before abort.
REQ-002 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports mem_read_m / mem_write_m  in  1  MEM-stage load / store request.
REQ-005 SHALL have port data_type_m  in  3  access type (package encoding).
REQ-006 SHALL have ports addr_m / wdata_m  in  32  byte address / store data.
REQ-007 SHALL have port stall_o  out  1  high holds the pipeline; drives pipeline-register en low.
REQ-008 SHALL have ports done_o  out  1  and err_o  out  1  completion pulse / error pulse.
REQ-009 SHALL have port rdata_o  out  32  extended load result, valid while done_o high.
REQ-010 SHALL have ports bus_req, bus_we  out  1; bus_addr, bus_wdata  out  32; bus_be  out  4.
REQ-011 SHALL have ports bus_ack  in  1  and bus_rdata  in  32  (rdata valid with ack).

Function
REQ-012 SHALL implement FSM IDLE, REQ, DONE; IDLE->REQ when mem_read_m|mem_write_m, REQ->DONE on bus_ack or timeout, DONE->IDLE unconditionally.
REQ-013 SHALL drive stall_o = (IDLE and request) or REQ, combinationally; low in DONE.
REQ-014 SHALL register bus_req/bus_we/bus_addr/bus_be/bus_wdata on the IDLE->REQ edge and hold them stable until ack.
REQ-015 SHALL drive bus_addr = {addr_m[31:2],2'b00}.
REQ-016 SHALL use byte enables: word 1111; half 0011 (addr[1]=0) / 1100 (addr[1]=1); byte 0001<<addr[1:0].
REQ-017 SHALL replicate store data: word as-is; half {h,h}; byte {b,b,b,b}.
REQ-018 SHALL capture bus_rdata on ack, select lane by addr[1:0], sign- or zero-extend per type into rdata_o.
REQ-019 SHALL pulse done_o for exactly the DONE cycle; request with ack in cycle K yields done_o at K+1.
REQ-020 SHALL ignore request inputs in DONE (no double issue of the held instruction).
REQ-021 SHALL count REQ cycles; at TIMEOUT_CYC without ack, drop bus_req, go DONE, pulse err_o, rdata_o = 0.
REQ-022 SHALL treat mem_read_m and mem_write_m both high as a store; rdata_o = 0.
REQ-023 SHALL force rdata_o = 0 for stores and when done_o low.

Reset
REQ-024 SHALL on reset, including mid-REQ, enter IDLE, clear counter, deassert bus_req next cycle, zero all registered outputs.

Configuration
REQ-025 SHALL, with MEM_ALIGN_CHECK_EN defined, flag word with addr[1:0]!=0 or half with addr[0]=1: no bus request, IDLE->DONE, err_o pulse in DONE, rdata_o = 0.
REQ-026 SHALL, without MEM_ALIGN_CHECK_EN, ignore misalignment; lanes chosen per REQ-016 only.

Structure
REQ-027 SHALL take data-type codes (000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned), FSM state encoding and TIMEOUT_CYC default from shared package mem_pkg.
REQ-028 SHALL place lane alignment (bus_be, store replication, load extraction) in combinational sub-module mem_lane_align.

Verification
REQ-029 SHALL test: word load addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> stall 4 cycles, done_o once, rdata_o 0xDEADBEEF.
REQ-030 SHALL test: signed byte load addr 0x103, bus_rdata 0x80112233 -> bus_be 1000, rdata_o 0xFFFFFF80.
REQ-031 SHALL test: unsigned half store addr 0x202, wdata 0x0000ABCD -> bus_we 1, bus_be 1100, bus_wdata 0xABCDABCD.
REQ-032 SHALL test: no ack for TIMEOUT_CYC cycles -> err_o one pulse, bus_req low, stall released.
REQ-033 SHALL test: reset asserted in 2nd REQ cycle -> bus_req low next cycle, state IDLE, outputs zero.
REQ-034 SHALL test (MEM_ALIGN_CHECK_EN): word load addr 0x101 -> no bus_req, stall one cycle, err_o pulse.
